// File: rtl/dvi_video_driver.sv
// dvi_video_driver: source side of a CH7301C DVI link.
// Generates H/V/DE frame timing from a line/frame counter pair and packs an
// RGB555 pixel stream into 12-bit rise/fall half-words for ODDR pad cells.
// Optional feature: define TEST_PATTERN_EN to add the test_pattern input,
// which replaces the stream with 8 vertical colour bars.
//
// Handshake: a pixel transfers on a rising clk edge when pixel_valid and
// pixel_ready are both 1. pixel_ready is high exactly in the cycle before an
// edge that will drive dvi_de=1, so the accepted pixel appears on dvi_data_*
// at that same edge. If pixel_valid is 0 in such a cycle the slot is driven
// black and the pixel is not fetched later.
module dvi_video_driver #(
  parameter int H_FRONT_PORCH = 24,
  parameter int H_SYNC        = 136,
  parameter int H_BACK_PORCH  = 160,
  parameter int H_VISIBLE     = 1024,
  parameter int V_FRONT_PORCH = 3,
  parameter int V_SYNC        = 6,
  parameter int V_BACK_PORCH  = 29,
  parameter int V_VISIBLE     = 768,
  parameter bit SYNC_POLARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [11:0] dvi_data_rise,
  output logic [11:0] dvi_data_fall,
  output logic        dvi_de,
  output logic        dvi_h,
  output logic        dvi_v,
  output logic        dvi_reset_b,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
`ifdef TEST_PATTERN_EN
  ,
  input  logic        test_pattern
`endif
);

  localparam int H_TOTAL = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH + H_VISIBLE;
  localparam int V_TOTAL = V_FRONT_PORCH + V_SYNC + V_BACK_PORCH + V_VISIBLE;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_DE_START = HW'(H_SYNC + H_BACK_PORCH);
  localparam logic [HW-1:0] H_DE_END   = HW'(H_SYNC + H_BACK_PORCH + H_VISIBLE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_LST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_BP_LST   = VW'(V_SYNC + V_BACK_PORCH - 1);
  localparam logic [VW-1:0] V_ACT_LST  = VW'(V_SYNC + V_BACK_PORCH + V_VISIBLE - 1);

  typedef enum logic [1:0] {ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP} state_t;

  // Counters hold the position whose outputs are driven at the next edge.
  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            h_sync_slot;
  logic            de_slot;
  logic [14:0]     pixel_rgb;

  // Decode the current position into sync and visible slots.
  always_comb begin
    h_sync_slot = (state == ST_ACTIVE) && (h_cnt < H_SYNC_END);
    de_slot     = (state == ST_ACTIVE) && (h_cnt >= H_DE_START) && (h_cnt < H_DE_END);
  end

`ifdef TEST_PATTERN_EN
  logic            tp_line;
  logic [HW-1:0]   x_pos;
  logic [2:0]      x_bar;

  // Pixel source: colour bars when the line was started in pattern mode.
  always_comb begin
    x_pos       = h_cnt - H_DE_START;
    x_bar       = 3'((32'(x_pos) * 8) / H_VISIBLE);
    pixel_ready = de_slot && !tp_line;
    if (tp_line) pixel_rgb = {{5{x_bar[2]}}, {5{x_bar[1]}}, {5{x_bar[0]}}};
    else         pixel_rgb = pixel_valid ? pixel_data : 15'h0000;
  end

  // Pattern mode is latched at line start so a line never mixes sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tp_line <= 1'b0;
    else if (h_cnt == '0)    tp_line <= test_pattern;
  end
`else
  // Pixel source: the stream, black when the source starves a visible slot.
  always_comb begin
    pixel_ready = de_slot;
    pixel_rgb   = pixel_valid ? pixel_data : 15'h0000;
  end
`endif

  // Frame FSM, counters and all registered video outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_VSYNC;
      h_cnt         <= '0;
      v_cnt         <= '0;
      dvi_de        <= 1'b0;
      dvi_h         <= ~SYNC_POLARITY;
      dvi_v         <= ~SYNC_POLARITY;
      dvi_data_rise <= 12'h000;
      dvi_data_fall <= 12'h000;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      dvi_reset_b   <= 1'b0;
    end else begin
      dvi_reset_b <= 1'b1;
      dvi_de      <= de_slot;
      dvi_h       <= h_sync_slot ? SYNC_POLARITY : ~SYNC_POLARITY;
      dvi_v       <= (state == ST_VSYNC) ? SYNC_POLARITY : ~SYNC_POLARITY;
      frame_start <= (state == ST_VSYNC) && (v_cnt == '0) && (h_cnt == '0);
      if (de_slot) begin
        dvi_data_rise <= {1'b0, pixel_rgb[14:10], pixel_rgb[9:8], 4'b0000};
        dvi_data_fall <= {pixel_rgb[7:5], pixel_rgb[4:0], 4'b0000};
      end else begin
        dvi_data_rise <= 12'h000;
        dvi_data_fall <= 12'h000;
      end
      // A new starvation event outranks a simultaneous clear.
      if (pixel_ready && !pixel_valid) underflow <= 1'b1;
      else if (underflow_clr)          underflow <= 1'b0;

      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
          state <= ST_VSYNC;
        end else begin
          v_cnt <= v_cnt + 1'b1;
          case (state)
            ST_VSYNC:  if (v_cnt == V_SYNC_LST) state <= ST_VBP;
            ST_VBP:    if (v_cnt == V_BP_LST)   state <= ST_ACTIVE;
            ST_ACTIVE: if (v_cnt == V_ACT_LST)  state <= ST_VFP;
            default:   state <= ST_VFP;
          endcase
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvi_video_driver.sv
// Bench for dvi_video_driver with a small timing (line 17, frame 153 clocks).
// A position model predicts every output each cycle; a second instance with
// SYNC_POLARITY=1 checks that only H/V change polarity.
module tb_dvi_video_driver;

  localparam int HFP = 2, HS = 3, HBP = 4, HV = 8;
  localparam int VFP = 1, VS = 2, VBP = 2, VV = 4;
  localparam int HT = HFP + HS + HBP + HV;
  localparam int VT = VFP + VS + VBP + VV;
  localparam int ACT0 = VS + VBP;
  localparam int DE0 = HS + HBP;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] pixel_data = 15'h0000;
  logic        pixel_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        pixel_ready, dvi_de, dvi_h, dvi_v, dvi_reset_b, frame_start, underflow;
  logic [11:0] dvi_data_rise, dvi_data_fall;
  logic        p_ready, p_de, p_h, p_v, p_reset_b, p_fs, p_uf;
  logic [11:0] p_rise, p_fall;
`ifdef TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  dvi_video_driver #(
    .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_VISIBLE(HV),
    .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_VISIBLE(VV),
    .SYNC_POLARITY(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .dvi_data_rise(dvi_data_rise), .dvi_data_fall(dvi_data_fall),
    .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v), .dvi_reset_b(dvi_reset_b),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
`ifdef TEST_PATTERN_EN
    , .test_pattern(test_pattern)
`endif
  );

  dvi_video_driver #(
    .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_VISIBLE(HV),
    .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_VISIBLE(VV),
    .SYNC_POLARITY(1'b1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(p_ready), .dvi_data_rise(p_rise), .dvi_data_fall(p_fall),
    .dvi_de(p_de), .dvi_h(p_h), .dvi_v(p_v), .dvi_reset_b(p_reset_b),
    .frame_start(p_fs), .underflow(p_uf), .underflow_clr(underflow_clr)
`ifdef TEST_PATTERN_EN
    , .test_pattern(test_pattern)
`endif
  );

  // Pixel stimulus and hand-packed {rise, fall} words.
  logic [14:0] pix_tbl[5] = '{15'h7FFF, 15'h0421, 15'h7C00, 15'h03E0, 15'h001F};
  logic [23:0] exp_tbl[5] = '{24'h7F0_FF0, 24'h040_210, 24'h7C0_000, 24'h030_E00, 24'h000_1F0};

  // scoreboard and position model
  logic [23:0] exp_q[$];
  int  checks = 0, errors = 0;
  int  mh = 0, mv = 0, pix_idx = 0, cyc = 0;
  bit  m_uf = 1'b0;
  int  cnt_v = 0, cnt_de = 0, first_h = -1, fs_n = 0;
  int  fs_at[2] = '{-1, -1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_act(input int v);
    return (v >= ACT0) && (v < ACT0 + VV);
  endfunction
  function automatic bit m_de(input int h, input int v);
    return m_act(v) && (h >= DE0) && (h < DE0 + HV);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_uf = 1'b0; cyc = 0;
    exp_q.delete();
  endtask

  task automatic model_advance();
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_de"}, dvi_de, 0);
    check({tag, "_h"}, dvi_h, 1);
    check({tag, "_v"}, dvi_v, 1);
    check({tag, "_rise"}, dvi_data_rise, 0);
    check({tag, "_fall"}, dvi_data_fall, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_uf"}, underflow, 0);
    check({tag, "_rstb"}, dvi_reset_b, 0);
    check({tag, "_ready"}, pixel_ready, 0);
    check({tag, "_ph"}, p_h, 0);
    check({tag, "_pv"}, p_v, 0);
  endtask

  // driver: one clock with given valid/clear, then full output check
  task automatic cycle(input bit valid, input bit clr);
    bit e_de, e_h, e_v, e_fs, e_uf;
    logic [23:0] e_data;
    int n_on;
    pixel_valid = valid;
    underflow_clr = clr;
    pixel_data = pix_tbl[pix_idx];
    e_de = m_de(mh, mv);
    e_h  = m_act(mv) && (mh < HS);
    e_v  = (mv < VS);
    e_fs = (mh == 0) && (mv == 0);
    e_uf = (e_de && !valid) ? 1'b1 : (clr ? 1'b0 : m_uf);
    if (e_de && valid) begin
      exp_q.push_back(exp_tbl[pix_idx]);
      pix_idx = (pix_idx + 1) % 5;
    end
    @(posedge clk);
    #1;
    e_data = 24'h0;
    if (e_de && exp_q.size() > 0) e_data = exp_q.pop_front();
    check("de", dvi_de, e_de);
    check("h", dvi_h, !e_h);
    check("v", dvi_v, !e_v);
    check("rise", dvi_data_rise, e_data[23:12]);
    check("fall", dvi_data_fall, e_data[11:0]);
    check("frame_start", frame_start, e_fs);
    check("underflow", underflow, e_uf);
    check("reset_b", dvi_reset_b, 1);
    check("pol_h", p_h, e_h);
    check("pol_v", p_v, e_v);
    check("pol_de", p_de, e_de);
    check("pol_rise", p_rise, e_data[23:12]);
    n_on = int'(!dvi_h) + int'(!dvi_v) + int'(dvi_de);
    check("one_of_hvde", n_on <= 1, 1);
    m_uf = e_uf;
    if (!dvi_v) cnt_v++;
    if (dvi_de) cnt_de++;
    if (!dvi_h && first_h < 0) first_h = cyc;
    if (frame_start) begin
      if (fs_n < 2) fs_at[fs_n] = cyc;
      fs_n++;
    end
    cyc++;
    model_advance();
    check("ready", pixel_ready, m_de(mh, mv));
  endtask

  initial begin
    bit drop, clr;
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    model_reset();

    // three frames: clean, underflow episodes, clear
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < HT * VT; i++) begin
        drop = (f == 1) && (mv == ACT0 || mv == ACT0 + 2) && (mh == DE0 + 3);
        clr  = ((f == 1) && ((mv == ACT0 + 1 && mh == 0) || (mv == ACT0 + 2 && mh == DE0 + 3)))
               || ((f == 2) && mv == 1 && mh == 0);
        cycle(!drop, clr);
      end
      if (f == 0) begin
        check("v_clocks", cnt_v, 34);
        check("de_clocks", cnt_de, 32);
        check("first_h", first_h, 68);
        check("fs0_at", fs_at[0], 0);
      end
      if (f == 1) begin
        check("fs1_at", fs_at[1], 153);
        check("uf_sticky", underflow, 1);
      end
      if (f == 2) check("uf_cleared", underflow, 0);
    end

    // asynchronous reset in the middle of a DE run on active line 2
    guard = 0;
    while (!(mv == ACT0 + 2 && mh == DE0 + 4) && guard < 400) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("reach_mid_de", guard < 400, 1);
    check("mid_de", dvi_de, 1);
    rst_n = 1'b0;
    #2;
    check_reset("async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0);

`ifdef TEST_PATTERN_EN
    // colour bars: stream ignored, ready held low
    rst_n = 1'b0;
    test_pattern = 1'b1;
    pixel_valid = 1'b1;
    pixel_data = 15'h7FFF;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < HT * VT; i++) begin
      bit e_de;
      int x;
      e_de = m_de(mh, mv);
      x = mh - DE0;
      check("tp_ready", pixel_ready, 0);
      @(posedge clk);
      #1;
      check("tp_de", dvi_de, e_de);
      check("tp_uf", underflow, 0);
      if (e_de && x == 0) begin
        check("tp_x0_rise", dvi_data_rise, 12'h000);
        check("tp_x0_fall", dvi_data_fall, 12'h000);
      end
      if (e_de && x == 7) begin
        check("tp_x7_rise", dvi_data_rise, 12'h7F0);
        check("tp_x7_fall", dvi_data_fall, 12'hFF0);
      end
      model_advance();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
